// File: rtl/ysyx_040066_mdu.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro YSYX_040066_MDU_EARLY_OUT_EN ends a multiply once the remaining multiplier is zero.
module ysyx_040066_mdu #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      mdu_op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic [1:0]      dbg_state
);
  localparam int H  = XLEN / 2;
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;
  state_t state, state_n;

  logic [2*XLEN-1:0] prod, prod_n, mcand, mcand_n;
  logic [XLEN-1:0]   mplier, mplier_n, quo, quo_n, rem, rem_n, result_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic              word_q, word_qn, hi_q, hi_qn, rem_q, rem_qn, neg_q, neg_qn;

  function automatic logic [XLEN-1:0] sext_h(input logic [XLEN-1:0] x);
    return {{(XLEN-H){x[H-1]}}, x[H-1:0]};
  endfunction

  // Operand decode, used only in the acceptance cycle.
  logic            is_div, mul_hi, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag;
  assign is_div   = mdu_op[2];
  assign mul_hi   = !is_div && (mdu_op[1:0] != 2'd0) && !word;
  assign a_sgn    = is_div ? !mdu_op[0] : (word || (mdu_op[1:0] != 2'd3));
  assign b_sgn    = is_div ? !mdu_op[0] : (word || !mdu_op[1]);
  assign a_ext    = !word ? src1 : (a_sgn ? sext_h(src1) : {{(XLEN-H){1'b0}}, src1[H-1:0]});
  assign b_ext    = !word ? src2 : (b_sgn ? sext_h(src2) : {{(XLEN-H){1'b0}}, src2[H-1:0]});
  assign a_neg    = a_sgn && a_ext[XLEN-1];
  assign b_neg    = b_sgn && b_ext[XLEN-1];
  assign a_mag    = a_neg ? -a_ext : a_ext;
  assign b_mag    = b_neg ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);
  assign div_ovf  = !mdu_op[0] && (b_ext == '1) &&
                    (a_ext == (word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}}));

  // One iteration of each datapath; the sign fix-up is folded into the final iteration.
  logic [2*XLEN-1:0] prod_step, prod_fix;
  logic [XLEN:0]     div_sh, div_diff;
  logic              div_ge, mul_last;
  logic [XLEN-1:0]   mplier_sh, quo_step, rem_step, quo_fix, rem_fix, mul_res, div_res;
  logic [CW-1:0]     last_cnt;
  assign prod_step = mplier[0] ? prod + mcand : prod;
  assign mplier_sh = mplier >> 1;
  assign prod_fix  = neg_q ? -prod_step : prod_step;
  assign mul_res   = word_q ? sext_h(prod_fix[XLEN-1:0])
                   : (hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0]);
  assign div_sh    = {rem, quo[XLEN-1]};
  assign div_diff  = div_sh - {1'b0, mplier};
  assign div_ge    = !div_diff[XLEN];
  assign rem_step  = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
  assign quo_step  = {quo[XLEN-2:0], div_ge};
  assign quo_fix   = neg_q ? -quo_step : quo_step;
  assign rem_fix   = neg_q ? -rem_step : rem_step;
  assign div_res   = rem_q ? (word_q ? sext_h(rem_fix) : rem_fix)
                           : (word_q ? sext_h(quo_fix) : quo_fix);
  assign last_cnt  = word_q ? CW'(H - 1) : CW'(XLEN - 1);
`ifdef YSYX_040066_MDU_EARLY_OUT_EN
  assign mul_last  = (cnt == last_cnt) || (mplier_sh == '0);
`else
  assign mul_last  = (cnt == last_cnt);
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
  // depends on ready, and result/out_valid hold steady until the transfer completes.
  assign in_ready  = (state == S_IDLE) && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    prod_n   = prod;
    mcand_n  = mcand;
    mplier_n = mplier;
    quo_n    = quo;
    rem_n    = rem;
    result_n = result;
    word_qn  = word_q;
    hi_qn    = hi_q;
    rem_qn   = rem_q;
    neg_qn   = neg_q;
    case (state)
      S_IDLE: if (in_valid && in_ready) begin
        word_qn = word;
        hi_qn   = mul_hi;
        rem_qn  = mdu_op[1];
        cnt_n   = '0;
        if (!is_div) begin
          neg_qn   = a_neg ^ b_neg;
          prod_n   = '0;
          mcand_n  = {{XLEN{1'b0}}, a_mag};
          mplier_n = b_mag;
          state_n  = S_MUL;
        end else if (div_zero) begin
          result_n = mdu_op[1] ? (word ? sext_h(a_ext) : a_ext) : '1;
          state_n  = S_DONE;
        end else if (div_ovf) begin
          result_n = mdu_op[1] ? '0 : a_ext;
          state_n  = S_DONE;
        end else begin
          neg_qn   = mdu_op[1] ? a_neg : (a_neg ^ b_neg);
          quo_n    = word ? (a_mag << H) : a_mag;
          rem_n    = '0;
          mplier_n = b_mag;
          state_n  = S_DIV;
        end
      end
      S_MUL: begin
        prod_n   = prod_step;
        mcand_n  = mcand << 1;
        mplier_n = mplier_sh;
        cnt_n    = cnt + CW'(1);
        if (mul_last) begin
          result_n = mul_res;
          state_n  = S_DONE;
        end
      end
      S_DIV: begin
        quo_n = quo_step;
        rem_n = rem_step;
        cnt_n = cnt + CW'(1);
        if (cnt == last_cnt) begin
          result_n = div_res;
          state_n  = S_DONE;
        end
      end
      S_DONE: if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (flush) begin
      state_n  = S_IDLE;
      result_n = result;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      prod   <= '0;
      mcand  <= '0;
      mplier <= '0;
      quo    <= '0;
      rem    <= '0;
      result <= '0;
      word_q <= 1'b0;
      hi_q   <= 1'b0;
      rem_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      prod   <= prod_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      quo    <= quo_n;
      rem    <= rem_n;
      result <= result_n;
      word_q <= word_qn;
      hi_q   <= hi_qn;
      rem_q  <= rem_qn;
      neg_q  <= neg_qn;
    end
  end
endmodule

// File: tb/tb_ysyx_040066_mdu.sv
// Bench for ysyx_040066_mdu: directed and random requests, expected results and latencies
// queued at issue and checked by an independent monitor.
module tb_ysyx_040066_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  mdu_op = 3'd0;
  logic        word = 1'b0;
  logic [63:0] src1 = '0, src2 = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic hold_ready = 1'b0;
  logic [63:0] exp_q[$];
  int lat_q[$];
  int acc_q[$];

  ysyx_040066_mdu #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mdu_op(mdu_op),
    .word(word), .src1(src1), .src2(src2), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_msg(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout/unexpected event, expected normal handshake", name);
  endtask

  // reference model
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, r32;
    logic [63:0]  r;
    longint       sa, sb;
    a32 = a[31:0];
    b32 = b[31:0];
    sa  = a;
    sb  = b;
    r   = '0;
    if (w) begin
      case (op)
        3'd4: if (b32 == 0) r32 = '1;
              else if (a32 == 32'h8000_0000 && b32 == '1) r32 = a32;
              else r32 = $signed(a32) / $signed(b32);
        3'd5: if (b32 == 0) r32 = '1; else r32 = a32 / b32;
        3'd6: if (b32 == 0) r32 = a32;
              else if (a32 == 32'h8000_0000 && b32 == '1) r32 = '0;
              else r32 = $signed(a32) % $signed(b32);
        3'd7: if (b32 == 0) r32 = a32; else r32 = a32 % b32;
        default: r32 = a32 * b32;
      endcase
      r = {{32{r32[31]}}, r32};
    end else begin
      case (op)
        3'd0: r = a * b;
        3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
        3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b}; r = p[127:64]; end
        3'd3: begin p = {64'd0, a} * {64'd0, b}; r = p[127:64]; end
        3'd4: if (b == 0) r = '1;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
              else r = sa / sb;
        3'd5: if (b == 0) r = '1; else r = a / b;
        3'd6: if (b == 0) r = a;
              else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
              else r = sa % sb;
        default: if (b == 0) r = a; else r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    int n;
    logic bz, ovf;
    n = w ? 32 : 64;
    if (op[2]) begin
      bz  = w ? (b[31:0] == 0) : (b == 0);
      ovf = !op[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
      return (bz || ovf) ? 1 : n + 1;
    end
`ifdef YSYX_040066_MDU_EARLY_OUT_EN
    begin
      longint sb;
      logic [63:0] bm;
      int k;
      logic sgn;
      sgn = w || (op <= 3'd1);
      sb  = w ? longint'($signed(b[31:0])) : $signed(b);
      if (sgn && sb < 0) bm = -sb;
      else bm = w ? {32'd0, b[31:0]} : b;
      k = 0;
      while (bm != 0) begin k++; bm = bm >> 1; end
      if (k == 0) k = 1;
      return k + 1;
    end
`else
    return n + 1;
`endif
  endfunction

  function automatic logic [63:0] rand_opnd();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'($urandom_range(0, 20));
      4: return 64'h0000_0000_8000_0000;
      5: return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // driver tasks (called at posedge + 1)
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] e, input int l);
    int t;
    t = 0;
    in_valid = 1'b1;
    mdu_op = op;
    word = w;
    src1 = a;
    src2 = b;
    exp_q.push_back(e);
    lat_q.push_back(l);
    @(negedge clk);
    while (!in_ready && t < 2000) begin @(negedge clk); t++; end
    if (!in_ready) begin
      fail_msg("accept_timeout");
      void'(exp_q.pop_back());
      void'(lat_q.pop_back());
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mdu_op = 3'($urandom);
    word = 1'($urandom);
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
  endtask

  task automatic issue_rand(input logic [2:0] op, input logic w, input logic [63:0] a,
                            input logic [63:0] b);
    issue(op, w, a, b, ref_model(op, w, a, b), ref_lat(op, w, a, b));
  endtask

  task automatic drain();
    int t;
    t = 0;
    @(posedge clk);
    while (exp_q.size() != 0 && t < 3000) begin @(posedge clk); t++; end
    if (exp_q.size() != 0) begin
      fail_msg("drain_timeout");
      exp_q.delete();
      lat_q.delete();
      acc_q.delete();
    end
    #1;
  endtask

  task automatic cancel_pending();
    void'(exp_q.pop_back());
    void'(lat_q.pop_back());
    if (acc_q.size() != 0) void'(acc_q.pop_back());
  endtask

  always @(posedge clk) begin
    #2;
    out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // scoreboard monitor
  logic        prev_ov = 1'b0, prev_hs = 1'b0, prev_ctl = 1'b1;
  logic [63:0] prev_res = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !prev_ov) begin
        if (lat_q.size() == 0 || acc_q.size() == 0) fail_msg("unexpected_valid");
        else check("latency", 64'(cyc - acc_q.pop_front()), 64'(lat_q.pop_front()));
      end
      if (out_valid) check("in_ready_in_done", {63'd0, in_ready}, 64'd0);
      if (prev_ov && !prev_hs && !prev_ctl) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_result", result, prev_res);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail_msg("unexpected_result");
        else check("result", result, exp_q.pop_front());
      end
    end
    prev_ov  = out_valid;
    prev_hs  = out_valid && out_ready;
    prev_ctl = rst || flush;
    prev_res = result;
  end

  initial begin
    int mlat_a, mlat_b, mlat_c;
`ifdef YSYX_040066_MDU_EARLY_OUT_EN
    mlat_a = 3; mlat_b = 65; mlat_c = 4;
`else
    mlat_a = 65; mlat_b = 65; mlat_c = 65;
`endif
    // reset held two cycles with a request pending
    rst = 1'b1;
    in_valid = 1'b1;
    mdu_op = 3'd4;
    src1 = 64'd55;
    src2 = 64'd3;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // directed values
    issue(3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, mlat_a);
    issue(3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, mlat_b);
    issue(3'd0, 1'b0, 64'd3, 64'd5, 64'd15, mlat_c);
    issue(3'd5, 1'b0, 64'd100, 64'd0, '1, 1);
    issue(3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
    issue(3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
    drain();

    // consumer stalls five cycles in DONE
    hold_ready = 1'b1;
    issue(3'd7, 1'b0, 64'd100, 64'd0, 64'd100, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    hold_ready = 1'b0;
    drain();

    // flush at c10 of a divide
    issue(3'd4, 1'b0, 64'd1000, 64'd7, 64'd142, 65);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    cancel_pending();
    @(negedge clk);
    check("post_flush_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_flush_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush_blocks_accept", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    issue(3'd5, 1'b0, 64'd100, 64'd7, 64'd14, 65);
    drain();

    // reset in the middle of a multiply
    issue_rand(3'd1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cancel_pending();
    @(negedge clk);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;

    // random traffic
    for (int i = 0; i < 150; i++) begin
      issue_rand(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), rand_opnd(), rand_opnd());
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
